// File: rtl/end_screen_ctrl.sv
// End-of-game overlay sequencer: result detect, frame-counted delay/show timeline,
// win/lose image select and return-to-menu req/ack. Optional: END_SCREEN_CLICK_SKIP_EN.
module end_screen_ctrl #(
    parameter int WIN_DELAY_FRAMES  = 0,
    parameter int LOSE_DELAY_FRAMES = 15,
    parameter int SHOW_FRAMES       = 300,
    parameter int BLINK_HALF        = 16,
    parameter int SKIP_MIN_FRAMES   = 60,
    parameter int CNT_W             = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       game_end,
    input  logic             vblnk_in,
    input  logic             mouse_left,
    input  logic             menu_ack,
    output logic             overlay_en,
    output logic             img_sel,
    output logic             back_to_menu_req,
    output logic             busy,
    output logic [CNT_W-1:0] frames_left
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_SHOW,
        S_REQ,
        S_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] WIN_D    = CNT_W'(WIN_DELAY_FRAMES);
    localparam logic [CNT_W-1:0] LOSE_D   = CNT_W'(LOSE_DELAY_FRAMES);
    localparam logic [CNT_W-1:0] SHOW_F   = CNT_W'(SHOW_FRAMES);
    localparam logic [CNT_W-1:0] BLINK_H  = CNT_W'(BLINK_HALF);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic             vblnk_prev;
    logic             tick;
    logic             ov_q, ov_d;
    logic             sel_q, sel_d;
    logic             req_q, req_d;
    logic [CNT_W-1:0] fl_q, fl_d;
    // Ticks since the last blink toggle; equals (SHOW - frames_left) mod BLINK_HALF.
    logic [CNT_W-1:0] blink_q, blink_d;
    logic             skip;

    assign tick = vblnk_in & ~vblnk_prev;

`ifdef END_SCREEN_CLICK_SKIP_EN
    localparam logic [CNT_W-1:0] SKIP_MIN = CNT_W'(SKIP_MIN_FRAMES);
    logic             click_prev;
    logic [CNT_W-1:0] show_elapsed;

    assign show_elapsed = SHOW_F - fl_q;
    assign skip         = mouse_left & ~click_prev & (show_elapsed >= SKIP_MIN);

    always_ff @(posedge clk) begin
        if (rst) click_prev <= 1'b0;
        else     click_prev <= mouse_left;
    end
`else
    logic unused_skip_inputs;
    assign unused_skip_inputs = mouse_left ^ SKIP_MIN_FRAMES[0];
    assign skip               = 1'b0;
`endif

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        ov_d    = ov_q;
        sel_d   = sel_q;
        req_d   = req_q;
        fl_d    = fl_q;
        blink_d = blink_q;
        case (state_q)
            S_IDLE: begin
                if (game_end == 2'd1) begin
                    sel_d   = 1'b0;
                    fl_d    = WIN_D;
                    state_d = S_DELAY;
                end else if (game_end == 2'd2) begin
                    sel_d   = 1'b1;
                    fl_d    = LOSE_D;
                    state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                if (fl_q == CNT_ZERO || (tick && fl_q == CNT_ONE)) begin
                    ov_d    = 1'b1;
                    fl_d    = SHOW_F;
                    blink_d = CNT_ZERO;
                    state_d = S_SHOW;
                end else if (tick) begin
                    fl_d = fl_q - CNT_ONE;
                end
            end
            S_SHOW: begin
                // overlay_en keeps its current blink phase on the way into REQ.
                if (fl_q == CNT_ZERO || (tick && fl_q == CNT_ONE) || skip) begin
                    req_d   = 1'b1;
                    fl_d    = CNT_ZERO;
                    state_d = S_REQ;
                end else if (tick) begin
                    fl_d = fl_q - CNT_ONE;
                    if (BLINK_H != CNT_ZERO) begin
                        if (blink_q == BLINK_H - CNT_ONE) begin
                            blink_d = CNT_ZERO;
                            ov_d    = ~ov_q;
                        end else begin
                            blink_d = blink_q + CNT_ONE;
                        end
                    end
                end
            end
            S_REQ: begin
                if (menu_ack) begin
                    req_d   = 1'b0;
                    ov_d    = 1'b0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (game_end == 2'd0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            vblnk_prev <= 1'b0;
            ov_q       <= 1'b0;
            sel_q      <= 1'b0;
            req_q      <= 1'b0;
            fl_q       <= CNT_ZERO;
            blink_q    <= CNT_ZERO;
        end else begin
            state_q    <= state_d;
            vblnk_prev <= vblnk_in;
            ov_q       <= ov_d;
            sel_q      <= sel_d;
            req_q      <= req_d;
            fl_q       <= fl_d;
            blink_q    <= blink_d;
        end
    end

    assign overlay_en       = ov_q;
    assign img_sel          = sel_q;
    assign back_to_menu_req = req_q;
    assign busy             = (state_q != S_IDLE);
    assign frames_left      = fl_q;

endmodule

// File: tb/tb_end_screen_ctrl.sv
// Self-checking bench for end_screen_ctrl: directed rounds with randomized frame
// spacing and game_end noise, expectations from a timeline model of the sequence.
module tb_end_screen_ctrl;

    localparam int WIN_D    = 0;
    localparam int LOSE_D   = 3;
    localparam int SHOW_F   = 8;
    localparam int BH       = 2;
    localparam int SKIP_MIN = 2;
    localparam int CW       = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    game_end;
    logic          vblnk_in;
    logic          mouse_left;
    logic          menu_ack;
    logic          overlay_en;
    logic          img_sel;
    logic          back_to_menu_req;
    logic          busy;
    logic [CW-1:0] frames_left;

    end_screen_ctrl #(
        .WIN_DELAY_FRAMES (WIN_D),
        .LOSE_DELAY_FRAMES(LOSE_D),
        .SHOW_FRAMES      (SHOW_F),
        .BLINK_HALF       (BH),
        .SKIP_MIN_FRAMES  (SKIP_MIN),
        .CNT_W            (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .game_end        (game_end),
        .vblnk_in        (vblnk_in),
        .mouse_left      (mouse_left),
        .menu_ack        (menu_ack),
        .overlay_en      (overlay_en),
        .img_sel         (img_sel),
        .back_to_menu_req(back_to_menu_req),
        .busy            (busy),
        .frames_left     (frames_left)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs after the most recent clock edge.
    bit e_ov, e_sel, e_req, e_busy;
    int e_fl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_now(input string tag);
        chk({tag, ".overlay_en"}, 32'(overlay_en), 32'(e_ov));
        chk({tag, ".img_sel"}, 32'(img_sel), 32'(e_sel));
        chk({tag, ".req"}, 32'(back_to_menu_req), 32'(e_req));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".frames_left"}, 32'(frames_left), 32'(e_fl));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Overlay level after k SHOW ticks: starts on, flips every BH ticks.
    function automatic bit show_ov(input int k);
        if (BH == 0) return 1'b1;
        return ((k / BH) % 2) == 0;
    endfunction

    // One frame: tick edge, vblank held a little, then a low gap; game_end is noise.
    task automatic frame(input string tag);
        vblnk_in = 1'b1;
        game_end = 2'($urandom_range(0, 3));
        cyc();
        expect_now(tag);
        repeat ($urandom_range(0, 2)) begin
            game_end = 2'($urandom_range(0, 3));
            cyc();
            expect_now(tag);
        end
        vblnk_in = 1'b0;
        repeat ($urandom_range(1, 4)) begin
            game_end = 2'($urandom_range(0, 3));
            cyc();
            expect_now(tag);
        end
    endtask

    task automatic round(input int res, input bit ack_early, input bit do_skip,
                         input int rst_at, output bit aborted);
        int delay;
        bit done;
        delay   = (res == 2) ? LOSE_D : WIN_D;
        aborted = 1'b0;
        done    = 1'b0;

        game_end = 2'(res);
        cyc();
        e_ov = 0; e_sel = (res == 2); e_req = 0; e_busy = 1; e_fl = delay;
        expect_now("enter");

        if (delay == 0) begin
            game_end = 2'($urandom_range(0, 3));
            cyc();
            e_ov = 1; e_fl = SHOW_F;
            expect_now("zero_delay");
        end else begin
            for (int k = 1; k <= delay; k++) begin
                if (k < delay) begin
                    e_ov = 0; e_fl = delay - k;
                end else begin
                    e_ov = 1; e_fl = SHOW_F;
                end
                frame("delay");
            end
        end

        if (ack_early) menu_ack = 1'b1;

        for (int k = 1; k < SHOW_F && !done; k++) begin
            e_fl = SHOW_F - k;
            e_ov = show_ov(k);
            frame("show");
            if (rst_at == k) begin
                game_end = 2'd1;
                rst      = 1'b1;
                cyc();
                e_ov = 0; e_sel = 0; e_req = 0; e_busy = 0; e_fl = 0;
                expect_now("mid_rst");
                rst      = 1'b0;
                menu_ack = 1'b0;
                aborted  = 1'b1;
                return;
            end
            if (do_skip && (k == 1 || k == 2)) begin
                mouse_left = 1'b1;
                cyc();
`ifdef END_SCREEN_CLICK_SKIP_EN
                if (k >= SKIP_MIN) begin
                    e_req = 1; e_fl = 0; done = 1'b1;
                end
`endif
                expect_now("click");
                mouse_left = 1'b0;
                if (!done) begin
                    cyc();
                    expect_now("click_release");
                end
            end
        end

        if (!done) begin
            vblnk_in = 1'b1;
            cyc();
            e_req = 1; e_fl = 0;
            expect_now("to_req");
            vblnk_in = 1'b0;
        end

        if (ack_early) begin
            cyc();
        end else begin
            repeat ($urandom_range(0, 3)) begin
                game_end = 2'($urandom_range(0, 3));
                cyc();
                expect_now("req_hold");
            end
            menu_ack = 1'b1;
            cyc();
        end
        e_req = 0; e_ov = 0;
        expect_now("ack");
        menu_ack = 1'b0;

        game_end = 2'(res);
        repeat (3) begin
            cyc();
            expect_now("release_hold");
        end
        game_end = 2'd3;
        cyc();
        expect_now("release_invalid");
        game_end = 2'd0;
        cyc();
        e_busy = 0;
        expect_now("back_idle");
        game_end = 2'd3;
        repeat (2) cyc();
        expect_now("idle_invalid");
        game_end = 2'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ab;
        rst        = 1'b1;
        vblnk_in   = 1'b0;
        mouse_left = 1'b0;
        menu_ack   = 1'b0;
        game_end   = 2'd1;
        repeat (3) cyc();
        e_ov = 0; e_sel = 0; e_req = 0; e_busy = 0; e_fl = 0;
        expect_now("reset");
        rst      = 1'b0;
        game_end = 2'd0;
        menu_ack = 1'b1;
        cyc();
        expect_now("idle");
        menu_ack = 1'b0;

        round(1, 1'b0, 1'b0, 0, ab);
        round(2, 1'b0, 1'b0, 0, ab);
        round(2, 1'b1, 1'b0, 0, ab);
        round(1, 1'b0, 1'b0, 3, ab);
        chk("rst_aborted", 32'(ab), 32'd1);
        round(1, 1'b0, 1'b0, 0, ab);
        round(2, 1'b0, 1'b1, 0, ab);
        round(1, 1'b0, 1'b1, 0, ab);

        for (int r = 0; r < 8; r++) begin
            round(int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)), 1'b0, 0, ab);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
